decode_execute_stage: RTL and testbench

DECODE_EXECUTE_STAGE -- requirements
Module: decode_execute_stage

---
 rtl/decode_execute_stage_pkg.sv | 24 ++
 rtl/decode_execute_stage_if.sv | 50 +++++
 rtl/decode_execute_stage_detect.sv | 40 ++++
 rtl/decode_execute_stage.sv | 156 +++++++++++++++
 tb/tb_decode_execute_stage.sv | 367 ++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/decode_execute_stage_pkg.sv
// Shared definitions for the decode -> execute boundary: control bundle width,
// bubble values and the per-cycle action taken by the execute register.
package decode_execute_stage_pkg;

    // Default width of the opaque execute-control bundle.
    localparam int CTRL_W = 8;

    // Execute-control bundle as seen by decode, this stage and execute.
    typedef logic [CTRL_W-1:0] ctrl_t;

    // Values loaded into the execute register when it holds no instruction.
    localparam logic [4:0]  BUBBLE_REG = 5'd0;
    localparam logic [31:0] BUBBLE_IMM = 32'd0;
    localparam logic [31:0] RESET_PC   = 32'd0;

    // What the execute register does on the next rising edge.
    typedef enum logic [1:0] {
        ACT_ADVANCE,
        ACT_HOLD,
        ACT_FLUSH,
        ACT_HAZARD
    } x_action_e;

endpackage

// File: rtl/decode_execute_stage_if.sv
// Signal bundle between the decode stage, the decode/execute register and the
// surrounding pipeline control (branch redirect, memory stall, counters).
interface decode_execute_stage_if #(
    parameter int CTRL_W = decode_execute_stage_pkg::CTRL_W,
    parameter int CNT_W  = 16
);
    logic              d_valid;
    logic [31:0]       d_pc;
    logic [4:0]        d_rs1;
    logic [4:0]        d_rs2;
    logic [4:0]        d_rd;
    logic              d_uses_rs1;
    logic              d_uses_rs2;
    logic              d_reg_wen;
    logic              d_mem_read;
    logic [31:0]       d_imm;
    logic [CTRL_W-1:0] d_ctrl;
    logic              x_branch_taken;
    logic              m_stall;

    logic              x_valid;
    logic [31:0]       x_pc;
    logic [4:0]        x_rs1;
    logic [4:0]        x_rs2;
    logic [4:0]        x_rd;
    logic              x_reg_wen;
    logic              x_mem_read;
    logic [31:0]       x_imm;
    logic [CTRL_W-1:0] x_ctrl;
    logic              stall_fd;
    logic [CNT_W-1:0]  load_use_count;
    logic [CNT_W-1:0]  flush_count;

    // Side that supplies decoded instructions and pipeline events.
    modport master (
        output d_valid, d_pc, d_rs1, d_rs2, d_rd, d_uses_rs1, d_uses_rs2,
               d_reg_wen, d_mem_read, d_imm, d_ctrl, x_branch_taken, m_stall,
        input  x_valid, x_pc, x_rs1, x_rs2, x_rd, x_reg_wen, x_mem_read,
               x_imm, x_ctrl, stall_fd, load_use_count, flush_count
    );

    // The decode/execute stage itself.
    modport slave (
        input  d_valid, d_pc, d_rs1, d_rs2, d_rd, d_uses_rs1, d_uses_rs2,
               d_reg_wen, d_mem_read, d_imm, d_ctrl, x_branch_taken, m_stall,
        output x_valid, x_pc, x_rs1, x_rs2, x_rd, x_reg_wen, x_mem_read,
               x_imm, x_ctrl, stall_fd, load_use_count, flush_count
    );

endinterface

// File: rtl/decode_execute_stage_detect.sv
// Combinational load-use hazard detector and fetch/decode stall generator.
module load_use_detect
    import decode_execute_stage_pkg::*;
(
    input  logic       reset,
    input  logic       x_valid,
    input  logic       x_mem_read,
    input  logic [4:0] x_rd,
    input  logic       d_valid,
    input  logic       d_uses_rs1,
    input  logic       d_uses_rs2,
    input  logic [4:0] d_rs1,
    input  logic [4:0] d_rs2,
    input  logic       x_branch_taken,
    input  logic       m_stall,
    output logic       hazard,
    output logic       stall_fd
);

    logic rs1Match;
    logic rs2Match;

    // A load in execute whose result decode needs forces one bubble; a memory
    // stall freezes fetch/decode, a branch redirect never does, reset never does.
    always_comb begin
        rs1Match = d_uses_rs1 && (d_rs1 == x_rd);
        rs2Match = d_uses_rs2 && (d_rs2 == x_rd);
        hazard   = x_valid && x_mem_read && (x_rd != BUBBLE_REG) && d_valid
                   && (rs1Match || rs2Match);
        stall_fd = 1'b0;
        if (!reset) begin
            if (m_stall) begin
                stall_fd = 1'b1;
            end else if (!x_branch_taken) begin
                stall_fd = hazard;
            end
        end
    end

endmodule

// File: rtl/decode_execute_stage.sv
// Decode/execute pipeline register with load-use bubble insertion, branch
// flush, memory-stall hold and saturating hazard/flush event counters.
module decode_execute_stage #(
    parameter int CTRL_W = decode_execute_stage_pkg::CTRL_W,
    parameter int CNT_W  = 16
) (
    input logic                   clk,
    input logic                   reset,
    decode_execute_stage_if.slave bus
);
    import decode_execute_stage_pkg::*;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    x_action_e         action;
    logic              hazard;
    logic              stallFd;

    logic              xValid_q,    xValid_d;
    logic [31:0]       xPc_q,       xPc_d;
    logic [4:0]        xRs1_q,      xRs1_d;
    logic [4:0]        xRs2_q,      xRs2_d;
    logic [4:0]        xRd_q,       xRd_d;
    logic              xRegWen_q,   xRegWen_d;
    logic              xMemRead_q,  xMemRead_d;
    logic [31:0]       xImm_q,      xImm_d;
    logic [CTRL_W-1:0] xCtrl_q,     xCtrl_d;
    logic [CNT_W-1:0]  loadUseCount_q, loadUseCount_d;
    logic [CNT_W-1:0]  flushCount_q,   flushCount_d;

    load_use_detect u_detect (
        .reset          (reset),
        .x_valid        (xValid_q),
        .x_mem_read     (xMemRead_q),
        .x_rd           (xRd_q),
        .d_valid        (bus.d_valid),
        .d_uses_rs1     (bus.d_uses_rs1),
        .d_uses_rs2     (bus.d_uses_rs2),
        .d_rs1          (bus.d_rs1),
        .d_rs2          (bus.d_rs2),
        .x_branch_taken (bus.x_branch_taken),
        .m_stall        (bus.m_stall),
        .hazard         (hazard),
        .stall_fd       (stallFd)
    );

    // Resolve this cycle's event: memory stall beats redirect beats load-use.
    always_comb begin
        action = ACT_ADVANCE;
        if (bus.m_stall) begin
            action = ACT_HOLD;
        end else if (bus.x_branch_taken) begin
            action = ACT_FLUSH;
        end else if (hazard) begin
            action = ACT_HAZARD;
        end
    end

    // Next execute-register contents: hold, bubble, or the decoded instruction
    // with unused source indices and invalid destinations cleared.
    always_comb begin
        xValid_d   = xValid_q;
        xPc_d      = xPc_q;
        xRs1_d     = xRs1_q;
        xRs2_d     = xRs2_q;
        xRd_d      = xRd_q;
        xRegWen_d  = xRegWen_q;
        xMemRead_d = xMemRead_q;
        xImm_d     = xImm_q;
        xCtrl_d    = xCtrl_q;
        unique case (action)
            ACT_HOLD: begin
            end
            ACT_FLUSH, ACT_HAZARD: begin
                xValid_d   = 1'b0;
                xPc_d      = bus.d_pc;
                xRs1_d     = BUBBLE_REG;
                xRs2_d     = BUBBLE_REG;
                xRd_d      = BUBBLE_REG;
                xRegWen_d  = 1'b0;
                xMemRead_d = 1'b0;
                xImm_d     = BUBBLE_IMM;
                xCtrl_d    = '0;
            end
            ACT_ADVANCE: begin
                xValid_d   = bus.d_valid;
                xPc_d      = bus.d_pc;
                xRs1_d     = bus.d_uses_rs1 ? bus.d_rs1 : BUBBLE_REG;
                xRs2_d     = bus.d_uses_rs2 ? bus.d_rs2 : BUBBLE_REG;
                xRd_d      = bus.d_valid ? bus.d_rd : BUBBLE_REG;
                xRegWen_d  = bus.d_valid && bus.d_reg_wen;
                xMemRead_d = bus.d_mem_read;
                xImm_d     = bus.d_imm;
                xCtrl_d    = bus.d_ctrl;
            end
            default: begin
            end
        endcase
    end

    // Event counters stick at all-ones instead of wrapping.
    always_comb begin
        loadUseCount_d = loadUseCount_q;
        flushCount_d   = flushCount_q;
        if ((action == ACT_HAZARD) && (loadUseCount_q != CNT_MAX)) begin
            loadUseCount_d = loadUseCount_q + CNT_ONE;
        end
        if ((action == ACT_FLUSH) && (flushCount_q != CNT_MAX)) begin
            flushCount_d = flushCount_q + CNT_ONE;
        end
    end

    // State update; reset drops any pending hold or bubble and empties execute.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xValid_q       <= 1'b0;
            xPc_q          <= RESET_PC;
            xRs1_q         <= BUBBLE_REG;
            xRs2_q         <= BUBBLE_REG;
            xRd_q          <= BUBBLE_REG;
            xRegWen_q      <= 1'b0;
            xMemRead_q     <= 1'b0;
            xImm_q         <= BUBBLE_IMM;
            xCtrl_q        <= '0;
            loadUseCount_q <= '0;
            flushCount_q   <= '0;
        end else begin
            xValid_q       <= xValid_d;
            xPc_q          <= xPc_d;
            xRs1_q         <= xRs1_d;
            xRs2_q         <= xRs2_d;
            xRd_q          <= xRd_d;
            xRegWen_q      <= xRegWen_d;
            xMemRead_q     <= xMemRead_d;
            xImm_q         <= xImm_d;
            xCtrl_q        <= xCtrl_d;
            loadUseCount_q <= loadUseCount_d;
            flushCount_q   <= flushCount_d;
        end
    end

    assign bus.x_valid        = xValid_q;
    assign bus.x_pc           = xPc_q;
    assign bus.x_rs1          = xRs1_q;
    assign bus.x_rs2          = xRs2_q;
    assign bus.x_rd           = xRd_q;
    assign bus.x_reg_wen      = xRegWen_q;
    assign bus.x_mem_read     = xMemRead_q;
    assign bus.x_imm          = xImm_q;
    assign bus.x_ctrl         = xCtrl_q;
    assign bus.stall_fd       = stallFd;
    assign bus.load_use_count = loadUseCount_q;
    assign bus.flush_count    = flushCount_q;

endmodule

// File: tb/tb_decode_execute_stage.sv
// Scoreboard bench for decode_execute_stage: a behavioural model predicts each
// cycle's stall and execute-register contents; a monitor compares them.
module tb_decode_execute_stage;

    localparam int CTRL_W  = 8;
    localparam int CNT_W   = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    typedef struct {
        logic              valid;
        logic [31:0]       pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              usesRs1;
        logic              usesRs2;
        logic              regWen;
        logic              memRead;
        logic [31:0]       imm;
        logic [CTRL_W-1:0] ctrl;
        logic              branch;
        logic              mstall;
    } stim_t;

    typedef struct {
        logic              valid;
        logic [31:0]       pc;
        logic [4:0]        rs1;
        logic [4:0]        rs2;
        logic [4:0]        rd;
        logic              regWen;
        logic              memRead;
        logic [31:0]       imm;
        logic [CTRL_W-1:0] ctrl;
    } xstate_t;

    typedef struct {
        logic    stallFd;
        xstate_t x;
        int      loadUse;
        int      flush;
    } expect_t;

    logic    clk;
    logic    reset;
    int      assertCount;
    int      failCount;
    xstate_t modelX;
    int      modelLoadUse;
    int      modelFlush;
    expect_t sbQueue[$];

    decode_execute_stage_if #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) bus ();

    decode_execute_stage #(.CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Free-running clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so a stuck run still ends with a visible failure.
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: time limit reached before the end of stimulus");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        assertCount++;
        if (actual !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic xstate_t bubbleAt(input logic [31:0] pc);
        xstate_t b;
        b.valid   = 1'b0;
        b.pc      = pc;
        b.rs1     = 5'd0;
        b.rs2     = 5'd0;
        b.rd      = 5'd0;
        b.regWen  = 1'b0;
        b.memRead = 1'b0;
        b.imm     = 32'd0;
        b.ctrl    = '0;
        return b;
    endfunction

    function automatic stim_t mkInstr(input logic [31:0] pc, input logic [4:0] rs1, input logic [4:0] rs2,
                                      input logic [4:0] rd, input logic u1, input logic u2, input logic wen,
                                      input logic mread, input logic [31:0] imm, input logic [CTRL_W-1:0] ctrl);
        stim_t s;
        s.valid   = 1'b1;
        s.pc      = pc;
        s.rs1     = rs1;
        s.rs2     = rs2;
        s.rd      = rd;
        s.usesRs1 = u1;
        s.usesRs2 = u2;
        s.regWen  = wen;
        s.memRead = mread;
        s.imm     = imm;
        s.ctrl    = ctrl;
        s.branch  = 1'b0;
        s.mstall  = 1'b0;
        return s;
    endfunction

    // Reference behaviour: a frozen pipeline keeps execute; a redirect kills
    // the decode instruction; a decode instruction needing a load's result
    // waits one cycle; otherwise the decode instruction moves into execute.
    task automatic modelStep(input stim_t s, output expect_t e);
        logic    needsLoad;
        xstate_t nx;
        needsLoad = modelX.valid && modelX.memRead && (modelX.rd != 5'd0) && s.valid
                    && ((s.usesRs1 && (s.rs1 == modelX.rd)) || (s.usesRs2 && (s.rs2 == modelX.rd)));
        if (s.mstall) begin
            e.stallFd = 1'b1;
            nx = modelX;
        end else if (s.branch) begin
            e.stallFd = 1'b0;
            nx = bubbleAt(s.pc);
            if (modelFlush < CNT_MAX) modelFlush++;
        end else if (needsLoad) begin
            e.stallFd = 1'b1;
            nx = bubbleAt(s.pc);
            if (modelLoadUse < CNT_MAX) modelLoadUse++;
        end else begin
            e.stallFd  = 1'b0;
            nx.valid   = s.valid;
            nx.pc      = s.pc;
            nx.rs1     = s.usesRs1 ? s.rs1 : 5'd0;
            nx.rs2     = s.usesRs2 ? s.rs2 : 5'd0;
            nx.rd      = s.valid ? s.rd : 5'd0;
            nx.regWen  = s.valid && s.regWen;
            nx.memRead = s.memRead;
            nx.imm     = s.imm;
            nx.ctrl    = s.ctrl;
        end
        modelX    = nx;
        e.x       = nx;
        e.loadUse = modelLoadUse;
        e.flush   = modelFlush;
    endtask

    // Drive one cycle of inputs and queue the predicted response.
    task automatic applyStimulus(input stim_t s);
        expect_t e;
        @(negedge clk);
        bus.d_valid        = s.valid;
        bus.d_pc           = s.pc;
        bus.d_rs1          = s.rs1;
        bus.d_rs2          = s.rs2;
        bus.d_rd           = s.rd;
        bus.d_uses_rs1     = s.usesRs1;
        bus.d_uses_rs2     = s.usesRs2;
        bus.d_reg_wen      = s.regWen;
        bus.d_mem_read     = s.memRead;
        bus.d_imm          = s.imm;
        bus.d_ctrl         = s.ctrl;
        bus.x_branch_taken = s.branch;
        bus.m_stall        = s.mstall;
        modelStep(s, e);
        sbQueue.push_back(e);
    endtask

    task automatic settle();
        @(posedge clk);
        #1;
    endtask

    // Assert reset at a falling edge, leaving the current inputs in place, and
    // confirm everything clears at once without waiting for a clock.
    task automatic resetDut();
        @(negedge clk);
        reset = 1'b1;
        sbQueue.delete();
        modelX       = bubbleAt(32'd0);
        modelLoadUse = 0;
        modelFlush   = 0;
        #1;
        checkOutput("rst_x_valid",    64'(bus.x_valid),        64'd0);
        checkOutput("rst_x_pc",       64'(bus.x_pc),           64'd0);
        checkOutput("rst_x_rs1",      64'(bus.x_rs1),          64'd0);
        checkOutput("rst_x_rs2",      64'(bus.x_rs2),          64'd0);
        checkOutput("rst_x_rd",       64'(bus.x_rd),           64'd0);
        checkOutput("rst_x_reg_wen",  64'(bus.x_reg_wen),      64'd0);
        checkOutput("rst_x_mem_read", 64'(bus.x_mem_read),     64'd0);
        checkOutput("rst_x_imm",      64'(bus.x_imm),          64'd0);
        checkOutput("rst_x_ctrl",     64'(bus.x_ctrl),         64'd0);
        checkOutput("rst_stall_fd",   64'(bus.stall_fd),       64'd0);
        checkOutput("rst_load_use",   64'(bus.load_use_count), 64'd0);
        checkOutput("rst_flush",      64'(bus.flush_count),    64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        bus.m_stall        = 1'b0;
        bus.x_branch_taken = 1'b0;
        bus.d_valid        = 1'b0;
        reset              = 1'b0;
    endtask

    // Load x9 into execute, then a consumer of x9: one hazard bubble, then advance.
    task automatic doLoadUse(input logic [31:0] basePc);
        stim_t ld;
        stim_t use_;
        ld   = mkInstr(basePc, 5'd2, 5'd0, 5'd9, 1'b1, 1'b0, 1'b1, 1'b1, 32'h10, 8'h11);
        use_ = mkInstr(basePc + 32'd4, 5'd3, 5'd9, 5'd12, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 8'h22);
        applyStimulus(ld);
        applyStimulus(use_);
        applyStimulus(use_);
    endtask

    // Monitor: stall_fd just before the edge, execute state and counters just after.
    initial begin
        expect_t cur;
        forever begin
            @(negedge clk);
            #3;
            if (sbQueue.size() > 0) begin
                cur = sbQueue[0];
                checkOutput("stall_fd", 64'(bus.stall_fd), 64'(cur.stallFd));
                @(posedge clk);
                #1;
                if (sbQueue.size() > 0) begin
                    cur = sbQueue.pop_front();
                    checkOutput("x_valid",        64'(bus.x_valid),        64'(cur.x.valid));
                    checkOutput("x_pc",           64'(bus.x_pc),           64'(cur.x.pc));
                    checkOutput("x_rs1",          64'(bus.x_rs1),          64'(cur.x.rs1));
                    checkOutput("x_rs2",          64'(bus.x_rs2),          64'(cur.x.rs2));
                    checkOutput("x_rd",           64'(bus.x_rd),           64'(cur.x.rd));
                    checkOutput("x_reg_wen",      64'(bus.x_reg_wen),      64'(cur.x.regWen));
                    checkOutput("x_mem_read",     64'(bus.x_mem_read),     64'(cur.x.memRead));
                    checkOutput("x_imm",          64'(bus.x_imm),          64'(cur.x.imm));
                    checkOutput("x_ctrl",         64'(bus.x_ctrl),         64'(cur.x.ctrl));
                    checkOutput("load_use_count", 64'(bus.load_use_count), 64'(cur.loadUse));
                    checkOutput("flush_count",    64'(bus.flush_count),    64'(cur.flush));
                end
            end
        end
    end

    // Directed scenarios, randomized traffic and a final reset during a stall.
    initial begin
        stim_t s;
        assertCount = 0;
        failCount   = 0;
        reset       = 1'b1;
        s = mkInstr(32'd0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 8'd0);
        s.valid = 1'b0;
        bus.d_valid = 1'b0; bus.d_pc = '0; bus.d_rs1 = '0; bus.d_rs2 = '0; bus.d_rd = '0;
        bus.d_uses_rs1 = 1'b0; bus.d_uses_rs2 = 1'b0; bus.d_reg_wen = 1'b0; bus.d_mem_read = 1'b0;
        bus.d_imm = '0; bus.d_ctrl = '0; bus.x_branch_taken = 1'b0; bus.m_stall = 1'b0;
        resetDut();

        // lw x5 then add x6,x5,x7: one bubble, then the add enters execute.
        applyStimulus(mkInstr(32'h100, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 8'h01));
        applyStimulus(mkInstr(32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 8'h02));
        settle();
        checkOutput("lu_bubble_valid", 64'(bus.x_valid), 64'd0);
        checkOutput("lu_count_one",    64'(bus.load_use_count), 64'd1);
        applyStimulus(mkInstr(32'h104, 5'd5, 5'd7, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 8'h02));
        settle();
        checkOutput("lu_add_pc", 64'(bus.x_pc), 64'h104);

        // Load into x0 never creates a dependency.
        applyStimulus(mkInstr(32'h200, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h4, 8'h03));
        applyStimulus(mkInstr(32'h204, 5'd0, 5'd0, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 8'h04));
        settle();
        checkOutput("x0_no_stall_valid", 64'(bus.x_valid), 64'd1);
        checkOutput("x0_lu_unchanged",   64'(bus.load_use_count), 64'd1);

        // Hazard and redirect together: redirect wins, no stall.
        applyStimulus(mkInstr(32'h300, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 8'h05));
        s = mkInstr(32'h304, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 8'h06);
        s.branch = 1'b1;
        applyStimulus(s);
        settle();
        checkOutput("br_bubble_valid", 64'(bus.x_valid), 64'd0);
        checkOutput("br_flush_one",    64'(bus.flush_count), 64'd1);
        checkOutput("br_lu_unchanged", 64'(bus.load_use_count), 64'd1);

        // Memory stall freezes pc 0x40 in execute; a redirect held through it acts afterwards.
        applyStimulus(mkInstr(32'h40, 5'd1, 5'd2, 5'd3, 1'b1, 1'b1, 1'b1, 1'b0, 32'h7, 8'h07));
        s = mkInstr(32'h44, 5'd4, 5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 32'h9, 8'h08);
        s.mstall = 1'b1;
        s.branch = 1'b1;
        repeat (3) applyStimulus(s);
        settle();
        checkOutput("mstall_pc_held",  64'(bus.x_pc), 64'h40);
        checkOutput("mstall_stall_fd", 64'(bus.stall_fd), 64'd1);
        checkOutput("mstall_flush",    64'(bus.flush_count), 64'd1);
        s.mstall = 1'b0;
        applyStimulus(s);
        settle();
        checkOutput("held_branch_flush", 64'(bus.flush_count), 64'd2);

        // Unused rs2 never reaches execute.
        applyStimulus(mkInstr(32'h500, 5'd3, 5'h0A, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0, 32'h1, 8'h09));
        settle();
        checkOutput("unused_rs2_zero", 64'(bus.x_rs2), 64'd0);

        // Drive the load-use counter to one below the top, then past it.
        for (int i = 0; i < CNT_MAX - 2; i++) doLoadUse(32'h1000 + 32'(i * 16));
        settle();
        checkOutput("lu_near_max", 64'(bus.load_use_count), 64'(CNT_MAX - 1));
        for (int i = 0; i < 3; i++) doLoadUse(32'h2000 + 32'(i * 16));
        settle();
        checkOutput("lu_saturated", 64'(bus.load_use_count), 64'(CNT_MAX));

        // Randomized traffic with small register indices so hazards are frequent.
        for (int i = 0; i < 1500; i++) begin
            s.valid   = ($urandom_range(0, 99) < 80);
            s.pc      = $urandom();
            s.rs1     = 5'($urandom_range(0, 7));
            s.rs2     = 5'($urandom_range(0, 7));
            s.rd      = 5'($urandom_range(0, 7));
            s.usesRs1 = 1'($urandom_range(0, 1));
            s.usesRs2 = 1'($urandom_range(0, 1));
            s.regWen  = 1'($urandom_range(0, 1));
            s.memRead = ($urandom_range(0, 99) < 35);
            s.imm     = $urandom();
            s.ctrl    = 8'($urandom());
            s.branch  = ($urandom_range(0, 99) < 5);
            s.mstall  = ($urandom_range(0, 99) < 15);
            applyStimulus(s);
        end

        // Reset in the middle of a stall with a pending hazard in the pipe.
        applyStimulus(mkInstr(32'h600, 5'd1, 5'd0, 5'd5, 1'b1, 1'b0, 1'b1, 1'b1, 32'h8, 8'h0A));
        s = mkInstr(32'h604, 5'd5, 5'd0, 5'd6, 1'b1, 1'b0, 1'b1, 1'b0, 32'h0, 8'h0B);
        s.mstall = 1'b1;
        applyStimulus(s);
        applyStimulus(s);
        resetDut();

        // First cycles after reset follow ordinary priority rules from a clean state.
        for (int i = 0; i < 40; i++) begin
            s.valid   = ($urandom_range(0, 99) < 80);
            s.pc      = $urandom();
            s.rs1     = 5'($urandom_range(0, 3));
            s.rs2     = 5'($urandom_range(0, 3));
            s.rd      = 5'($urandom_range(0, 3));
            s.usesRs1 = 1'($urandom_range(0, 1));
            s.usesRs2 = 1'($urandom_range(0, 1));
            s.regWen  = 1'($urandom_range(0, 1));
            s.memRead = ($urandom_range(0, 99) < 40);
            s.imm     = $urandom();
            s.ctrl    = 8'($urandom());
            s.branch  = ($urandom_range(0, 99) < 10);
            s.mstall  = ($urandom_range(0, 99) < 10);
            applyStimulus(s);
        end

        repeat (3) @(negedge clk);
        checkOutput("scoreboard_drained", 64'(sbQueue.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
